line_pingpong: RTL

LINE_PINGPONG -- requirements
Module: line_pingpong

---
 rtl/line_pingpong_pkg.sv | 22 ++
 rtl/line_pingpong_blockmem.sv | 32 +++
 rtl/line_pingpong.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_pingpong_pkg.sv
// Shared types and helpers for the line ping-pong buffer.
package line_pingpong_pkg;

  // Write side: filling a bank, waiting for a free bank, or discarding an over-long line.
  typedef enum logic [1:0] {
    WR_FILL = 2'd0,
    WR_WAIT = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  // Read side: idle until the current read bank holds a line, then stream it.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_e;

  // Address width: one extra bit so a length of exactly WIDTH is representable.
  function automatic int addr_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/line_pingpong_blockmem.sv
// Simple dual-port line memory: synchronous write, synchronous read with one cycle latency.
module line_pingpong_blockmem
  import line_pingpong_pkg::*;
#(
  parameter int BITS  = 10,
  parameter int WIDTH = 640
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [addr_w(WIDTH)-1:0]  waddr,
  input  logic [BITS-1:0]           wdata,
  input  logic                      re,
  input  logic [addr_w(WIDTH)-1:0]  raddr,
  output logic [BITS-1:0]           rdata
);

  localparam int ADDR_W = addr_w(WIDTH);
  localparam int IDX_W  = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(WIDTH);

  logic [BITS-1:0] r_mem [WIDTH];
  logic [BITS-1:0] r_rdata;

  // Storage array and read register; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && (waddr < LIMIT)) r_mem[waddr[IDX_W-1:0]] <= wdata;
    if (re && (raddr < LIMIT)) r_rdata <= r_mem[raddr[IDX_W-1:0]];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/line_pingpong.sv
// Two-bank line buffer: one bank fills from the input while the other drains to the output.
module line_pingpong
  import line_pingpong_pkg::*;
#(
  parameter int BITS  = 10,
  parameter int WIDTH = 640
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  input  logic            in_eol,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_eol,
  output logic            overflow
);

  localparam int ADDR_W = addr_w(WIDTH);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH - 1);

  wr_state_e         r_wr_state, w_wr_state_n;
  logic              r_wr_bank, w_wr_bank_n;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_n;
  logic [1:0]        r_full, w_set, w_free;
  logic [ADDR_W-1:0] r_len [2];
  logic              w_len_we, w_we, w_ovf_set, r_overflow, r_alive;
  rd_state_e         r_rd_state, w_rd_state_n;
  logic              r_rd_bank, w_rd_bank_n;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_n;
  logic              w_issue, w_rd_last;
  logic [BITS-1:0]   r_fifo_data [2];
  logic [1:0]        r_fifo_eol;
  logic [1:0]        r_fifo_cnt;
  logic              r_pend, r_pend_bank, r_pend_eol;
  logic [BITS-1:0]   w_rdata0, w_rdata1, w_rdata;
  logic [BITS-1:0]   w_s0_data, w_s1_data;
  logic              w_s0_eol, w_s1_eol;
  logic              w_in_fire, w_pop, w_room, w_other_avail;

  // r_alive holds in_ready low until the first edge after reset release.
  assign in_ready      = r_alive && (r_wr_state != WR_WAIT);
  assign w_in_fire     = in_valid && in_ready;
  assign w_pop         = out_valid && out_ready;
  // A bank freed by the reader this cycle counts as available to the writer.
  assign w_other_avail = !r_full[!r_wr_bank] || w_free[!r_wr_bank];
  // Entries already queued plus the read in flight must leave room after this cycle's pop.
  assign w_room        = ({1'b0, r_fifo_cnt} + {2'b00, r_pend}) < (3'd2 + {2'b00, w_pop});

  // Write FSM next-state: fill, close lines, handle overflow and bank hand-over.
  always_comb begin
    w_wr_state_n = r_wr_state;
    w_wr_bank_n  = r_wr_bank;
    w_wr_addr_n  = r_wr_addr;
    w_we         = 1'b0;
    w_set        = 2'b00;
    w_len_we     = 1'b0;
    w_ovf_set    = 1'b0;
    case (r_wr_state)
      WR_FILL: begin
        if (w_in_fire) begin
          w_we = 1'b1;
          if (in_eol || (r_wr_addr == ADDR_LAST)) begin
            w_len_we    = 1'b1;
            w_set       = r_wr_bank ? 2'b10 : 2'b01;
            w_wr_addr_n = ADDR_ZERO;
            if (!in_eol) begin
              w_ovf_set    = 1'b1;
              w_wr_state_n = WR_DROP;
            end else if (w_other_avail) begin
              w_wr_bank_n  = !r_wr_bank;
              w_wr_state_n = WR_FILL;
            end else begin
              w_wr_state_n = WR_WAIT;
            end
          end else begin
            w_wr_addr_n = r_wr_addr + ADDR_ONE;
          end
        end else begin
          w_wr_state_n = WR_FILL;
        end
      end
      WR_WAIT: begin
        if (w_other_avail) begin
          w_wr_bank_n  = !r_wr_bank;
          w_wr_state_n = WR_FILL;
        end else begin
          w_wr_state_n = WR_WAIT;
        end
      end
      WR_DROP: begin
        if (w_in_fire && in_eol) begin
          if (w_other_avail) begin
            w_wr_bank_n  = !r_wr_bank;
            w_wr_state_n = WR_FILL;
          end else begin
            w_wr_state_n = WR_WAIT;
          end
        end else begin
          w_wr_state_n = WR_DROP;
        end
      end
      default: w_wr_state_n = WR_FILL;
    endcase
  end

  // Read FSM next-state: issue one address per cycle while the output queue has room.
  always_comb begin
    w_rd_state_n = r_rd_state;
    w_rd_bank_n  = r_rd_bank;
    w_rd_addr_n  = r_rd_addr;
    w_issue      = 1'b0;
    w_rd_last    = 1'b0;
    w_free       = 2'b00;
    case (r_rd_state)
      RD_IDLE: begin
        if (r_full[r_rd_bank]) w_rd_state_n = RD_RUN;
        else                   w_rd_state_n = RD_IDLE;
      end
      RD_RUN: begin
        if (w_room) begin
          w_issue   = 1'b1;
          w_rd_last = (r_rd_addr == (r_len[r_rd_bank] - ADDR_ONE));
          if (w_rd_last) begin
            w_free       = r_rd_bank ? 2'b10 : 2'b01;
            w_rd_bank_n  = !r_rd_bank;
            w_rd_addr_n  = ADDR_ZERO;
            w_rd_state_n = r_full[!r_rd_bank] ? RD_RUN : RD_IDLE;
          end else begin
            w_rd_addr_n = r_rd_addr + ADDR_ONE;
          end
        end else begin
          w_rd_state_n = RD_RUN;
        end
      end
      default: w_rd_state_n = RD_IDLE;
    endcase
  end

  // Output ordering: queued entries first, then the RAM word returned this cycle.
  always_comb begin
    w_rdata = r_pend_bank ? w_rdata1 : w_rdata0;
    if (r_fifo_cnt != 2'd0) begin
      w_s0_data = r_fifo_data[0];
      w_s0_eol  = r_fifo_eol[0];
    end else begin
      w_s0_data = w_rdata;
      w_s0_eol  = r_pend_eol;
    end
    if (r_fifo_cnt == 2'd2) begin
      w_s1_data = r_fifo_data[1];
      w_s1_eol  = r_fifo_eol[1];
    end else begin
      w_s1_data = w_rdata;
      w_s1_eol  = r_pend_eol;
    end
  end

  assign out_valid = (r_fifo_cnt != 2'd0) || r_pend;
  assign out_data  = out_valid ? w_s0_data : {BITS{1'b0}};
  assign out_eol   = out_valid ? w_s0_eol : 1'b0;
  assign overflow  = r_overflow;

  // Write-side state, bank flags and line lengths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive    <= 1'b0;
      r_wr_state <= WR_FILL;
      r_wr_bank  <= 1'b0;
      r_wr_addr  <= ADDR_ZERO;
      r_full     <= 2'b00;
      r_len[0]   <= ADDR_ZERO;
      r_len[1]   <= ADDR_ZERO;
      r_overflow <= 1'b0;
    end else begin
      r_alive    <= 1'b1;
      r_wr_state <= w_wr_state_n;
      r_wr_bank  <= w_wr_bank_n;
      r_wr_addr  <= w_wr_addr_n;
      r_full     <= (r_full & ~w_free) | w_set;
      if (w_len_we) r_len[r_wr_bank] <= r_wr_addr + ADDR_ONE;
      r_overflow <= r_overflow | w_ovf_set;
    end
  end

  // Read-side state, in-flight read tracking and the two-entry output queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state     <= RD_IDLE;
      r_rd_bank      <= 1'b0;
      r_rd_addr      <= ADDR_ZERO;
      r_pend         <= 1'b0;
      r_pend_bank    <= 1'b0;
      r_pend_eol     <= 1'b0;
      r_fifo_cnt     <= 2'd0;
      r_fifo_eol     <= 2'b00;
      r_fifo_data[0] <= {BITS{1'b0}};
      r_fifo_data[1] <= {BITS{1'b0}};
    end else begin
      r_rd_state  <= w_rd_state_n;
      r_rd_bank   <= w_rd_bank_n;
      r_rd_addr   <= w_rd_addr_n;
      r_pend      <= w_issue;
      r_pend_bank <= r_rd_bank;
      r_pend_eol  <= w_rd_last;
      r_fifo_cnt  <= r_fifo_cnt + {1'b0, r_pend} - {1'b0, w_pop};
      if (w_pop) begin
        r_fifo_data[0] <= w_s1_data;
        r_fifo_eol[0]  <= w_s1_eol;
      end else begin
        r_fifo_data[0] <= w_s0_data;
        r_fifo_eol[0]  <= w_s0_eol;
        r_fifo_data[1] <= w_s1_data;
        r_fifo_eol[1]  <= w_s1_eol;
      end
    end
  end

  line_pingpong_blockmem #(.BITS(BITS), .WIDTH(WIDTH)) u_bank0 (
    .clk   (clk),
    .we    (w_we && !r_wr_bank),
    .waddr (r_wr_addr),
    .wdata (in_data),
    .re    (w_issue && !r_rd_bank),
    .raddr (r_rd_addr),
    .rdata (w_rdata0)
  );

  line_pingpong_blockmem #(.BITS(BITS), .WIDTH(WIDTH)) u_bank1 (
    .clk   (clk),
    .we    (w_we && r_wr_bank),
    .waddr (r_wr_addr),
    .wdata (in_data),
    .re    (w_issue && r_rd_bank),
    .raddr (r_rd_addr),
    .rdata (w_rdata1)
  );

endmodule
